// File: rtl/lbus_if_pkg.sv
// Shared definitions for the LBUS slave bridge: register map, CTRL/STATUS bit positions, FSM encoding.
package lbus_if_pkg;

   localparam logic [15:0] ADDR_STATUS   = 16'h0000;
   localparam logic [15:0] ADDR_CTRL     = 16'h0002;
   localparam logic [15:0] ADDR_OP_BASE  = 16'h0100;
   localparam logic [15:0] ADDR_RES_BASE = 16'h0180;

   localparam int CTRL_START = 0;
   localparam int CTRL_KRDY  = 1;
   localparam int CTRL_SRST  = 2;

   localparam int STAT_BUSY  = 0;
   localparam int STAT_DONE  = 1;
   localparam int STAT_TMO   = 2;
   localparam int STAT_KVLD  = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRDY = 2'd1,
      WAIT = 2'd2
   } state_e;

endpackage

// File: rtl/lbus_if_nch.sv
// Local-bus slave: NCH operand registers, start/busy/done sequencing with a timeout watchdog,
// and an RW-bit result captured from the core and read back as 16-bit words.
module lbus_if_nch
   import lbus_if_pkg::*;
#(
   parameter int DW      = 12,
   parameter int NCH     = 2,
   parameter int RW      = 128,
   parameter int TMO_CYC = 4096
) (
   input  logic              clk_top,
   input  logic              rst_top,
   input  logic [15:0]       lbus_a,
   input  logic [15:0]       lbus_di,
   input  logic              lbus_wr,
   input  logic              lbus_rd,
   output logic [15:0]       lbus_do,
   output logic [NCH*DW-1:0] op_bus,
   output logic              blk_krdy,
   output logic              blk_drdy,
   output logic              blk_en,
   output logic              blk_rstn,
   input  logic [RW-1:0]     blk_dout,
   input  logic              blk_kvld,
   input  logic              blk_dvld
);

   localparam int NRES = RW / 16;
   localparam int CW   = $clog2(TMO_CYC + 2);

   logic [1:0]             rsync_q;
   logic                   rst_n;
   logic [15:0]            wa_q;
   logic                   we_q;
   state_e                 state_q, state_d;
   logic [NCH-1:0][DW-1:0] op_q;
   logic [RW-1:0]          res_q;
   logic [CW-1:0]          cnt_q, cnt_inc;
   logic                   done_q, tmo_q, kvld_q, srst_q, krdy_q;
   logic [15:0]            do_q, rd_d;
   logic                   busy, ctrl_wr, start_req, srst_wr, krdy_wr;
   logic                   tmo_hit, cap_ok, tmo_set;
   logic                   unused_di;

   // Reset asserts immediately but is released only on a clock edge.
   always_ff @(posedge clk_top or negedge rst_top) begin
      if (!rst_top) rsync_q <= 2'b00;
      else          rsync_q <= {rsync_q[0], 1'b1};
   end
   assign rst_n = rsync_q[1];

   assign unused_di = ^lbus_di;

   assign ctrl_wr   = we_q && (wa_q == ADDR_CTRL);
   assign srst_wr   = ctrl_wr && lbus_di[CTRL_SRST];
   assign krdy_wr   = ctrl_wr && lbus_di[CTRL_KRDY];
   assign start_req = ctrl_wr && lbus_di[CTRL_START] && !lbus_di[CTRL_SRST] && (state_q == IDLE);

   // Watchdog counter saturates at all-ones so a long WAIT can never wrap back below TMO_CYC.
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
   assign tmo_hit = (TMO_CYC != 0) && (state_q == WAIT) && (cnt_inc == CW'(TMO_CYC));
   assign cap_ok  = (state_q == WAIT) && blk_dvld && !srst_wr;
   assign tmo_set = tmo_hit && !blk_dvld && !srst_wr;

   always_ff @(posedge clk_top or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_req) state_d = DRDY;
         DRDY:    state_d = WAIT;
         WAIT:    if (blk_dvld || tmo_hit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (srst_wr) state_d = IDLE;
   end

   always_comb begin
      busy     = (state_q != IDLE);
      blk_drdy = (state_q == DRDY);
      blk_krdy = krdy_q;
      blk_en   = !srst_q;
      blk_rstn = !srst_q;
   end

   always_comb begin
      rd_d = 16'h0000;
      if (lbus_a == ADDR_STATUS) rd_d = {12'h000, kvld_q, tmo_q, done_q, busy};
      for (int i = 0; i < NCH; i++)
         if (lbus_a == ADDR_OP_BASE + 16'(2 * i)) rd_d = 16'(op_q[i]);
      for (int j = 0; j < NRES; j++)
         if (lbus_a == ADDR_RES_BASE + 16'(2 * j)) rd_d = res_q[16*j +: 16];
   end

   // Address is latched with the strobe; data is taken one edge later via we_q.
   always_ff @(posedge clk_top or negedge rst_n) begin
      if (!rst_n) begin
         wa_q   <= '0;
         we_q   <= 1'b0;
         op_q   <= '0;
         res_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
         tmo_q  <= 1'b0;
         kvld_q <= 1'b0;
         srst_q <= 1'b0;
         krdy_q <= 1'b0;
         do_q   <= '0;
      end else begin
         we_q   <= lbus_wr;
         if (lbus_wr) wa_q <= lbus_a;
         krdy_q <= krdy_wr;
         if (ctrl_wr)  srst_q <= lbus_di[CTRL_SRST];
         if (krdy_wr)  kvld_q <= 1'b0;
         if (blk_kvld) kvld_q <= 1'b1;
         if (start_req) begin
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
         end
         if (cap_ok) begin
            done_q <= 1'b1;
            res_q  <= blk_dout;
         end
         if (tmo_set) tmo_q <= 1'b1;
         if (state_q == DRDY)      cnt_q <= '0;
         else if (state_q == WAIT) cnt_q <= cnt_inc;
         if (we_q && !busy)
            for (int i = 0; i < NCH; i++)
               if (wa_q == ADDR_OP_BASE + 16'(2 * i)) op_q[i] <= lbus_di[DW-1:0];
         if (!lbus_rd) do_q <= rd_d;
      end
   end

   assign lbus_do = do_q;
   assign op_bus  = op_q;

endmodule

// File: tb/tb_lbus_if_nch.sv
// Scenario bench for lbus_if_nch: bus writes/reads, start/done/timeout sequencing, soft reset, krdy/kvld.
module tb_lbus_if_nch;

   localparam int DW  = 12;
   localparam int NCH = 2;
   localparam int RW  = 128;
   localparam int TMO = 16;

   logic              clk_top = 1'b0;
   logic              rst_top = 1'b1;
   logic [15:0]       lbus_a  = '0;
   logic [15:0]       lbus_di = '0;
   logic              lbus_wr = 1'b0;
   logic              lbus_rd = 1'b1;
   logic [15:0]       lbus_do;
   logic [NCH*DW-1:0] op_bus;
   logic              blk_krdy, blk_drdy, blk_en, blk_rstn;
   logic [RW-1:0]     blk_dout = '0;
   logic              blk_kvld = 1'b0;
   logic              blk_dvld = 1'b0;

   int n_checks = 0;
   int n_err    = 0;
   int drdy_cnt = 0;
   logic [15:0]  exp_q[$];
   int           exp_i[$];
   logic [15:0]  rd, e;
   logic [RW-1:0] res_v;

   lbus_if_nch #(.DW(DW), .NCH(NCH), .RW(RW), .TMO_CYC(TMO)) dut (
      .clk_top(clk_top), .rst_top(rst_top),
      .lbus_a(lbus_a), .lbus_di(lbus_di), .lbus_wr(lbus_wr), .lbus_rd(lbus_rd),
      .lbus_do(lbus_do), .op_bus(op_bus),
      .blk_krdy(blk_krdy), .blk_drdy(blk_drdy), .blk_en(blk_en), .blk_rstn(blk_rstn),
      .blk_dout(blk_dout), .blk_kvld(blk_kvld), .blk_dvld(blk_dvld)
   );

   always #5 clk_top = ~clk_top;

   always @(negedge clk_top) if (blk_drdy === 1'b1) drdy_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk_top); lbus_a = a; lbus_di = d; lbus_wr = 1'b1;
      @(negedge clk_top); lbus_wr = 1'b0;
      @(negedge clk_top);
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
      @(negedge clk_top); lbus_a = a; lbus_rd = 1'b0;
      @(negedge clk_top); d = lbus_do; lbus_rd = 1'b1;
   endtask

   task automatic pulse_dvld(input logic [RW-1:0] v);
      @(negedge clk_top); blk_dout = v; blk_dvld = 1'b1;
      @(negedge clk_top); blk_dvld = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst_top = 1'b0;
      repeat (3) @(negedge clk_top);
      n_checks++; if (lbus_do !== 16'h0) begin n_err++; $display("FAIL rst_lbus_do: got %h want 0000", lbus_do); end
      n_checks++; if (op_bus !== '0) begin n_err++; $display("FAIL rst_op_bus: got %h want 0", op_bus); end
      n_checks++; if ({blk_krdy, blk_drdy, blk_en, blk_rstn} !== 4'b0011) begin
         n_err++; $display("FAIL rst_blk_ctl: got %b want 0011", {blk_krdy, blk_drdy, blk_en, blk_rstn}); end
      rst_top = 1'b1;
      repeat (3) @(negedge clk_top);
      exp_q.push_back(16'h0000);
      bus_read(16'h0000, rd); e = exp_q.pop_front();
      n_checks++; if (rd !== e) begin n_err++; $display("FAIL rst_status: got %h want %h", rd, e); end
   endtask

   task automatic test_operands();
      bus_write(16'h0100, 16'hABCD);
      bus_write(16'h0102, 16'd2773);
      n_checks++; if (op_bus !== {12'hAD5, 12'hBCD}) begin n_err++; $display("FAIL op_bus: got %h want ad5bcd", op_bus); end
      bus_write(16'h0103, 16'h0777);
      bus_write(16'h0110, 16'h0555);
      n_checks++; if (op_bus !== {12'hAD5, 12'hBCD}) begin n_err++; $display("FAIL op_odd_unmapped: got %h want ad5bcd", op_bus); end
      exp_q.push_back(16'h0BCD);
      bus_read(16'h0100, rd); e = exp_q.pop_front();
      n_checks++; if (rd !== e) begin n_err++; $display("FAIL op0_read: got %h want %h", rd, e); end
      lbus_a = 16'h0102;
      @(negedge clk_top);
      n_checks++; if (lbus_do !== 16'h0BCD) begin n_err++; $display("FAIL rd_hold: got %h want 0bcd", lbus_do); end
      exp_q.push_back(16'h0AD5);
      bus_read(16'h0102, rd); e = exp_q.pop_front();
      n_checks++; if (rd !== e) begin n_err++; $display("FAIL op1_read: got %h want %h", rd, e); end
      exp_q.push_back(16'h0000);
      bus_read(16'h0104, rd); e = exp_q.pop_front();
      n_checks++; if (rd !== e) begin n_err++; $display("FAIL unmapped_read: got %h want %h", rd, e); end
   endtask

   task automatic test_start();
      int c0;
      c0 = drdy_cnt;
      bus_write(16'h0002, 16'h0001);
      n_checks++; if (blk_drdy !== 1'b1) begin n_err++; $display("FAIL drdy_high: got %b want 1", blk_drdy); end
      @(negedge clk_top);
      n_checks++; if (blk_drdy !== 1'b0) begin n_err++; $display("FAIL drdy_one_cycle: got %b want 0", blk_drdy); end
      n_checks++; if (drdy_cnt !== c0 + 1) begin n_err++; $display("FAIL drdy_count: got %0d want %0d", drdy_cnt, c0 + 1); end
      exp_q.push_back(16'h0001);
      bus_read(16'h0000, rd); e = exp_q.pop_front();
      n_checks++; if (rd !== e) begin n_err++; $display("FAIL busy_status: got %h want %h", rd, e); end
   endtask

   task automatic test_result();
      res_v = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
      pulse_dvld(res_v);
      exp_q.push_back(16'h0002);
      bus_read(16'h0000, rd); e = exp_q.pop_front();
      n_checks++; if (rd !== e) begin n_err++; $display("FAIL done_status: got %h want %h", rd, e); end
      for (int j = 0; j < RW / 16; j++) exp_q.push_back(res_v[16*j +: 16]);
      for (int j = 0; j < RW / 16; j++) begin
         bus_read(16'h0180 + 16'(2 * j), rd); e = exp_q.pop_front();
         n_checks++; if (rd !== e) begin n_err++; $display("FAIL res%0d: got %h want %h", j, rd, e); end
      end
      pulse_dvld(128'h5555_5555_5555_5555_5555_5555_5555_5555);
      exp_q.push_back(16'hCDEF);
      bus_read(16'h0180, rd); e = exp_q.pop_front();
      n_checks++; if (rd !== e) begin n_err++; $display("FAIL dvld_idle_ignored: got %h want %h", rd, e); end
   endtask

   task automatic test_timeout();
      int k;
      bit found;
      bus_write(16'h0002, 16'h0001);
      lbus_a = 16'h0000; lbus_rd = 1'b0;
      k = 0; found = 1'b0;
      exp_i.push_back(TMO + 2);
      for (int c = 1; c <= 60 && !found; c++) begin
         @(negedge clk_top);
         if (lbus_do === 16'h0004) begin found = 1'b1; k = c; end
      end
      lbus_rd = 1'b1;
      n_checks++; if (k !== exp_i[0]) begin n_err++; $display("FAIL tmo_latency: got %0d want %0d", k, exp_i[0]); end
      void'(exp_i.pop_front());
      for (int j = 0; j < RW / 16; j++) exp_q.push_back(res_v[16*j +: 16]);
      for (int j = 0; j < RW / 16; j++) begin
         bus_read(16'h0180 + 16'(2 * j), rd); e = exp_q.pop_front();
         n_checks++; if (rd !== e) begin n_err++; $display("FAIL tmo_res%0d: got %h want %h", j, rd, e); end
      end
   endtask

   task automatic test_busy_ignore();
      int c0;
      c0 = drdy_cnt;
      bus_write(16'h0002, 16'h0001);
      bus_write(16'h0100, 16'h0FFF);
      bus_write(16'h0002, 16'h0001);
      n_checks++; if (op_bus !== {12'hAD5, 12'hBCD}) begin n_err++; $display("FAIL op_frozen: got %h want ad5bcd", op_bus); end
      n_checks++; if (drdy_cnt !== c0 + 1) begin n_err++; $display("FAIL start_while_busy: got %0d want %0d", drdy_cnt, c0 + 1); end
      res_v = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
      pulse_dvld(res_v);
      exp_q.push_back(res_v[48 +: 16]);
      bus_read(16'h0186, rd); e = exp_q.pop_front();
      n_checks++; if (rd !== e) begin n_err++; $display("FAIL res3_second: got %h want %h", rd, e); end
   endtask

   task automatic test_dvld_vs_timeout();
      bus_write(16'h0002, 16'h0001);
      repeat (TMO - 1) @(negedge clk_top);
      res_v = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
      pulse_dvld(res_v);
      exp_q.push_back(16'h0002);
      bus_read(16'h0000, rd); e = exp_q.pop_front();
      n_checks++; if (rd !== e) begin n_err++; $display("FAIL dvld_wins_status: got %h want %h", rd, e); end
      exp_q.push_back(res_v[15:0]);
      bus_read(16'h0180, rd); e = exp_q.pop_front();
      n_checks++; if (rd !== e) begin n_err++; $display("FAIL dvld_wins_res0: got %h want %h", rd, e); end
   endtask

   task automatic test_soft_reset();
      int c0;
      bus_write(16'h0002, 16'h0001);
      bus_write(16'h0002, 16'h0004);
      n_checks++; if ({blk_rstn, blk_en} !== 2'b00) begin n_err++; $display("FAIL srst_outputs: got %b want 00", {blk_rstn, blk_en}); end
      exp_q.push_back(16'h0000);
      bus_read(16'h0000, rd); e = exp_q.pop_front();
      n_checks++; if (rd !== e) begin n_err++; $display("FAIL srst_status: got %h want %h", rd, e); end
      exp_q.push_back(res_v[15:0]);
      bus_read(16'h0180, rd); e = exp_q.pop_front();
      n_checks++; if (rd !== e) begin n_err++; $display("FAIL srst_res0: got %h want %h", rd, e); end
      bus_write(16'h0002, 16'h0000);
      n_checks++; if ({blk_rstn, blk_en} !== 2'b11) begin n_err++; $display("FAIL srst_release: got %b want 11", {blk_rstn, blk_en}); end
      bus_write(16'h0002, 16'h0001);
      n_checks++; if (blk_drdy !== 1'b1) begin n_err++; $display("FAIL restart_drdy: got %b want 1", blk_drdy); end
      bus_write(16'h0002, 16'h0005);
      exp_q.push_back(16'h0000);
      bus_read(16'h0000, rd); e = exp_q.pop_front();
      n_checks++; if (rd !== e) begin n_err++; $display("FAIL srst_busy_abort: got %h want %h", rd, e); end
      bus_write(16'h0002, 16'h0000);
      c0 = drdy_cnt;
      bus_write(16'h0002, 16'h0005);
      @(negedge clk_top);
      n_checks++; if (drdy_cnt !== c0) begin n_err++; $display("FAIL srst_beats_start: got %0d want %0d", drdy_cnt, c0); end
      n_checks++; if (blk_rstn !== 1'b0) begin n_err++; $display("FAIL srst_with_start_rstn: got %b want 0", blk_rstn); end
      bus_write(16'h0002, 16'h0000);
   endtask

   task automatic test_krdy();
      bus_write(16'h0002, 16'h0002);
      n_checks++; if (blk_krdy !== 1'b1) begin n_err++; $display("FAIL krdy_high: got %b want 1", blk_krdy); end
      @(negedge clk_top);
      n_checks++; if (blk_krdy !== 1'b0) begin n_err++; $display("FAIL krdy_one_cycle: got %b want 0", blk_krdy); end
      blk_kvld = 1'b1;
      @(negedge clk_top); blk_kvld = 1'b0;
      exp_q.push_back(16'h0008);
      bus_read(16'h0000, rd); e = exp_q.pop_front();
      n_checks++; if (rd !== e) begin n_err++; $display("FAIL kvld_seen: got %h want %h", rd, e); end
      bus_write(16'h0002, 16'h0002);
      exp_q.push_back(16'h0000);
      bus_read(16'h0000, rd); e = exp_q.pop_front();
      n_checks++; if (rd !== e) begin n_err++; $display("FAIL kvld_clear: got %h want %h", rd, e); end
   endtask

   initial begin
      test_reset();
      test_operands();
      test_start();
      test_result();
      test_timeout();
      test_busy_ignore();
      test_dvld_vs_timeout();
      test_soft_reset();
      test_krdy();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
